// File: rtl/ntt_pkg.sv
// ntt_pkg: shared bank/read-FSM state types and the bit-reversal helper.
package ntt_pkg;

    typedef enum logic [1:0] {FILLING, FULL, DRAINING} bank_state_t;
    typedef enum logic [1:0] {IDLE, LOAD, SHOW} rd_state_t;

    // Widest index the bit-reversal helper supports.
    localparam int REV_W = 16;

    // Reverse the low n bits of v; bits at and above n are returned as zero.
    function automatic logic [REV_W-1:0] bit_reverse(input logic [REV_W-1:0] v, input int n);
        logic [REV_W-1:0] r;
        r = '0;
        for (int i = 0; i < REV_W; i++)
            if (i < n) r[i] = v[n-1-i];
        return r;
    endfunction

endpackage

// File: rtl/mod_reduce_once.sv
// mod_reduce_once: combinational single conditional subtract, maps [0, 2q) onto [0, q).
module mod_reduce_once #(
    parameter int W       = 32,
    parameter int MODULUS = 7681
) (
    input  logic [W-1:0] in_data,
    output logic [W-1:0] out_data
);

    assign out_data = (in_data >= W'(MODULUS)) ? in_data - W'(MODULUS) : in_data;

endmodule

// File: rtl/ntt_output_reorder.sv
// ntt_output_reorder: ping-pong reorder buffer for NTT results; macro NTT_REORDER_BITREV_EN selects bit-reversed read order.
module ntt_output_reorder
    import ntt_pkg::*;
#(
    parameter int W       = 32,
    parameter int MODULUS = 7681,
    parameter int RADIX   = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [W-1:0]             in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [W-1:0]             out_data,
    output logic [$clog2(RADIX)-1:0] out_index,
    output logic                     frame_done,
    output logic                     overflow
);

    localparam int LW = $clog2(RADIX);

    bank_state_t     bank_q [2];
    bank_state_t     bank_d [2];
    rd_state_t       st_q, st_d;
    logic            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ovf_q, ovf_d, we;
    logic [LW-1:0]   wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d, idx_q, idx_d, rd_addr;
    logic [W-1:0]    data_q, data_d, red_data;
    logic [W-1:0]    mem_q [2][RADIX];

    mod_reduce_once #(.W(W), .MODULUS(MODULUS)) u_reduce (
        .in_data (in_data),
        .out_data(red_data)
    );

`ifdef NTT_REORDER_BITREV_EN
    logic [REV_W-1:0] rev_full;
    assign rev_full = bit_reverse(REV_W'(rd_cnt_q), LW);
    assign rd_addr  = rev_full[LW-1:0];
`else
    assign rd_addr = rd_cnt_q;
`endif

    // Outputs are forced quiet while reset is held; the last word of a frame flags frame_done on its handshake.
    assign out_valid  = rst && st_q == SHOW;
    assign out_data   = rst ? data_q : '0;
    assign out_index  = rst ? idx_q : '0;
    assign frame_done = out_valid && out_ready && rd_cnt_q == LW'(RADIX - 1);
    assign overflow   = rst && ovf_q;

    // Write side fills the current bank, read side walks the FULL bank through LOAD/SHOW pairs.
    always_comb begin
        bank_d   = bank_q;
        wr_ptr_d = wr_ptr_q;
        wr_cnt_d = wr_cnt_q;
        ovf_d    = ovf_q;
        st_d     = st_q;
        rd_ptr_d = rd_ptr_q;
        rd_cnt_d = rd_cnt_q;
        data_d   = data_q;
        idx_d    = idx_q;
        we       = 1'b0;
        if (in_valid) begin
            if (bank_q[wr_ptr_q] == FILLING) begin
                we       = 1'b1;
                wr_cnt_d = wr_cnt_q + 1'b1;
                if (wr_cnt_q == LW'(RADIX - 1)) begin
                    bank_d[wr_ptr_q] = FULL;
                    wr_ptr_d         = ~wr_ptr_q;
                end
            end else begin
                ovf_d = 1'b1;
            end
        end
        case (st_q)
            IDLE: if (bank_q[rd_ptr_q] == FULL) begin
                bank_d[rd_ptr_q] = DRAINING;
                st_d             = LOAD;
            end
            LOAD: begin
                data_d = mem_q[rd_ptr_q][rd_addr];
                idx_d  = rd_addr;
                st_d   = SHOW;
            end
            SHOW: if (out_ready) begin
                rd_cnt_d = rd_cnt_q + 1'b1;
                st_d     = LOAD;
                if (rd_cnt_q == LW'(RADIX - 1)) begin
                    bank_d[rd_ptr_q] = FILLING;
                    rd_ptr_d         = ~rd_ptr_q;
                    st_d             = IDLE;
                end
            end
            default: st_d = IDLE;
        endcase
    end

    // Bank storage; contents are left untouched by reset since the bank states discard them.
    always_ff @(posedge clk) begin
        if (we) mem_q[wr_ptr_q][wr_cnt_q] <= red_data;
    end

    // Control and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            bank_q   <= '{FILLING, FILLING};
            st_q     <= IDLE;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            ovf_q    <= 1'b0;
            data_q   <= '0;
            idx_q    <= '0;
        end else begin
            bank_q   <= bank_d;
            st_q     <= st_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            ovf_q    <= ovf_d;
            data_q   <= data_d;
            idx_q    <= idx_d;
        end
    end

endmodule

// File: tb/tb_ntt_output_reorder.sv
// tb_ntt_output_reorder: randomized and directed checks of the reorder buffer against a frame-level model.
module tb_ntt_output_reorder;

    localparam int W   = 32;
    localparam int Q   = 7681;
    localparam int R   = 8;
    localparam int LW  = 3;

    typedef struct {
        bit last;
        int idx;
        int data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [W-1:0]  out_data;
    logic [LW-1:0] out_index;
    logic          frame_done;
    logic          overflow;

    bit   rand_ready = 1'b0;
    bit   ready_force = 1'b1;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    int   frame_buf[$];

    ntt_output_reorder #(.W(W), .MODULUS(Q), .RADIX(R)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_index (out_index),
        .frame_done(frame_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d want %0d at %0t", tag, got, want, $time);
        end
    endtask

    // Output order of natural position k: bit-reversed when the feature is built in.
    function automatic int rev(input int k);
`ifdef NTT_REORDER_BITREV_EN
        int r = 0;
        for (int b = 0; b < LW; b++)
            if ((k >> b) & 1) r |= 1 << (LW - 1 - b);
        return r;
`else
        return k;
`endif
    endfunction

    // Collect accepted words; a full frame becomes R expected outputs in read order.
    task automatic model_push(input int x);
        frame_buf.push_back(x);
        if (frame_buf.size() == R) begin
            for (int k = 0; k < R; k++) begin
                int i;
                exp_t e;
                i = rev(k);
                e.last = (k == R - 1);
                e.idx  = i;
                e.data = frame_buf[i] >= Q ? frame_buf[i] - Q : frame_buf[i];
                exp_q.push_back(e);
            end
            frame_buf.delete();
        end
    endtask

    task automatic put(input int x, input bit keep);
        in_valid = 1'b1;
        in_data  = W'(x);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        if (keep) model_push(x);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 3000) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 0);
    endtask

    task automatic chk_reset_outputs();
        chk("rst_valid", 64'(out_valid), 0);
        chk("rst_data", 64'(out_data), 0);
        chk("rst_index", 64'(out_index), 0);
        chk("rst_fd", 64'(frame_done), 0);
        chk("rst_ovf", 64'(overflow), 0);
    endtask

    always @(posedge clk) begin
        #1;
        out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_force;
    end

    // Every output cycle must match the head of the expected queue; it is popped on handshake.
    always @(negedge clk) begin
        if (rst) begin
            if (out_valid && exp_q.size() == 0) begin
                chk("valid_unexpected", 64'(out_valid), 0);
            end else if (out_valid) begin
                chk("index", 64'(out_index), 64'(exp_q[0].idx));
                chk("data", 64'(out_data), 64'(exp_q[0].data));
                chk("frame_done", 64'(frame_done), 64'(out_ready && exp_q[0].last));
                if (out_ready) void'(exp_q.pop_front());
            end else begin
                chk("frame_done_idle", 64'(frame_done), 0);
            end
        end
    end

    initial begin
        idle(2);
        chk_reset_outputs();
        rst = 1'b1;
        idle(1);

        // Ordered frame 0..7 with the two-edge latency from last write to first valid.
        for (int i = 0; i < R; i++) put(i, 1'b1);
        chk("lat_e0", 64'(out_valid), 0);
        idle(1);
        chk("lat_e1", 64'(out_valid), 0);
        idle(1);
        chk("lat_e2", 64'(out_valid), 1);
        wait_drain();

        // Reduction boundaries.
        put(Q, 1'b1);
        put(Q + 9, 1'b1);
        put(Q - 1, 1'b1);
        put(2 * Q - 1, 1'b1);
        for (int i = 0; i < R - 4; i++) put(int'($urandom_range(0, 2 * Q - 1)), 1'b1);
        wait_drain();

        // Backpressure: hold SHOW for five cycles, the monitor checks stability each cycle.
        ready_force = 1'b0;
        for (int i = 0; i < R; i++) put(int'($urandom_range(0, 2 * Q - 1)), 1'b1);
        begin
            int n = 0;
            while (!out_valid && n < 20) begin
                idle(1);
                n++;
            end
        end
        idle(5);
        chk("hold_valid", 64'(out_valid), 1);
        ready_force = 1'b1;
        wait_drain();
        chk("ovf_clean", 64'(overflow), 0);

        // Three back-to-back frames: the third finds both banks busy and is dropped.
        for (int k = 1; k <= 3 * R; k++) begin
            put(1000 + k, k <= 2 * R);
            chk($sformatf("ovf_after_%0d", k), 64'(overflow), 64'(k > 2 * R));
        end
        wait_drain();

        // Reset mid-frame discards the partial frame and clears the sticky flag.
        for (int i = 0; i < 4; i++) put(100 + i, 1'b1);
        rst = 1'b0;
        frame_buf.delete();
        idle(1);
        chk_reset_outputs();
        idle(1);
        rst = 1'b1;
        for (int i = 10; i < 10 + R; i++) put(i, 1'b1);
        wait_drain();
        chk("ovf_after_reset", 64'(overflow), 0);

        // Random gaps and random consumer, keeping the writer at most one frame ahead.
        rand_ready = 1'b1;
        for (int f = 0; f < 6; f++) begin
            int n = 0;
            while (exp_q.size() > R && n < 500) begin
                idle(1);
                n++;
            end
            chk("space_wait", 64'(exp_q.size() <= R), 1);
            for (int i = 0; i < R; i++) begin
                idle(int'($urandom_range(0, 2)));
                put(int'($urandom_range(0, 2 * Q - 1)), 1'b1);
            end
        end
        wait_drain();
        rand_ready = 1'b0;
        chk("ovf_final", 64'(overflow), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ntt_output_reorder.md
NTT_OUTPUT_REORDER -- requirements
Module: ntt_output_reorder

Interface
REQ-001 Parameter W, default 32: data width in bits.
REQ-002 Parameter MODULUS, default 7681: NTT prime q.
REQ-003 Parameter RADIX, default 8: samples per frame; SHALL be a power of two, at least 2.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-low reset.
REQ-006 in_valid  input  1  in_data carries one butterfly-stage result this cycle.
REQ-007 in_data  input  W  result from the upstream Montgomery multiplier, range [0, 2*MODULUS).
REQ-008 out_valid  output  1  out_data/out_index are valid.
REQ-009 out_ready  input  1  consumer accepts the current output.
REQ-010 out_data  output  W  fully reduced coefficient, range [0, MODULUS).
REQ-011 out_index  output  $clog2(RADIX)  natural-order coefficient index of out_data.
REQ-012 frame_done  output  1  one-cycle pulse on acceptance of the last word of a frame.
REQ-013 overflow  output  1  sticky flag: an input was dropped.

Function
REQ-014 Two banks of RADIX words, used ping-pong; each bank is FILLING, FULL or DRAINING.
REQ-015 Write side: on in_valid, if the write bank is FILLING, store in_data at wr_cnt and increment wr_cnt.
REQ-016 At wr_cnt = RADIX-1 with in_valid: the bank goes FULL, wr_cnt wraps to 0, and the write pointer toggles to the other bank.
REQ-017 Before storing, in_data >= MODULUS SHALL be reduced by subtracting MODULUS once; otherwise it is stored unchanged.
REQ-018 in_valid while the target bank is not FILLING: drop the word, leave wr_cnt unchanged, and set overflow on the next edge.
REQ-019 Read side FSM: IDLE -> LOAD when the read bank is FULL; LOAD -> SHOW; SHOW -> LOAD on handshake with rd_cnt < RADIX-1.
REQ-020 SHOW -> IDLE on handshake with rd_cnt = RADIX-1: the bank returns to FILLING, the read pointer toggles, and frame_done pulses in the same cycle as the handshake.
REQ-021 LOAD performs a registered read of the bank at address rev(rd_cnt); out_valid is 1 only in SHOW.
REQ-022 out_data, out_valid and out_index SHALL stay stable in SHOW while out_ready = 0.
REQ-023 out_index = rev(rd_cnt), where rev is the bit-reversal over $clog2(RADIX) bits.
REQ-024 A full bank reaches its first out_valid exactly 2 cycles after its last write.
REQ-025 A bank freed in cycle t is writable from cycle t+1; simultaneous last-write and last-read of opposite banks are both honoured.
REQ-026 Sustained throughput: one word every 2 cycles per frame, with the next frame captured concurrently.

Reset
REQ-027 While rst = 0: out_valid = 0, out_data = 0, out_index = 0, frame_done = 0, overflow = 0; both banks FILLING, pointers at bank 0, counters at 0, FSM in IDLE.
REQ-028 Reset mid-frame SHALL discard all partial and full bank contents; bank RAM contents need not clear.

Configuration
REQ-029 Macro NTT_REORDER_BITREV_EN defined: read address and out_index are rev(rd_cnt), as above.
REQ-030 Macro NTT_REORDER_BITREV_EN undefined: read address and out_index are rd_cnt (natural order pass-through); all other behaviour is identical.

Structure
REQ-031 Shared package ntt_pkg: bank_state_t enum (FILLING, FULL, DRAINING), rd_state_t enum (IDLE, LOAD, SHOW), and the function bit_reverse.
REQ-032 One sub-module, mod_reduce_once: combinational conditional subtract of MODULUS, instantiated on the write path.

Verification
REQ-033 RADIX=8, BITREV on, inputs 0..7, out_ready=1 -> out_index 0,4,2,6,1,5,3,7; out_data equal to out_index; frame_done pulses once.
REQ-034 Input 7681 then 7690 -> stored and output as 0 and 9; input 7680 -> 7680 unchanged.
REQ-035 Three back-to-back frames (24 inputs, in_valid continuously high, out_ready=1) -> first frame fully drained, overflow = 1 after the 17th input, words 17..24 dropped.
REQ-036 out_ready held 0 for 5 cycles in SHOW -> out_data/out_index constant, then advance one word per handshake.
REQ-037 Reset asserted after 4 inputs, then inputs 10..17 -> output contains only 10..17 in the REQ-033 order, overflow = 0.
REQ-038 BITREV undefined, inputs 0..7 -> out_index and out_data 0,1,2,...,7.
